// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: walks ROM A / ROM B in LANES-wide groups, hides the
// ROM read latency with an in-flight tag pipe plus a credit-limited return FIFO,
// and presents aligned operand bundles over a valid/ready handshake.
// Optional build macro: FETCH_PERF_EN (enables the saturating pass cycle counter).
module operand_fetch_sequencer #(
    parameter int unsigned LANES       = 16,
    parameter int unsigned A_DEPTH     = 4096,
    parameter int unsigned B_DEPTH     = 64,
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                       clock,
    input  logic                       reset_l,
    input  logic                       start,
    output logic [$clog2(A_DEPTH)-1:0] romA_addr,
    output logic [$clog2(B_DEPTH)-1:0] romB_addr,
    input  logic [LANES*8-1:0]         romA_q,
    input  logic [LANES*8-1:0]         romB_q,
    output logic [LANES*8-1:0]         opA,
    output logic [LANES*8-1:0]         opB,
    output logic                       op_valid,
    input  logic                       op_ready,
    output logic                       op_last,
    output logic                       done,
    output logic [15:0]                cycle_count
);

    localparam int unsigned AW = $clog2(A_DEPTH);
    localparam int unsigned BW = $clog2(B_DEPTH);
    localparam int unsigned DW = LANES * 8;
    localparam int unsigned FD = ROM_LATENCY + 2;
    localparam int unsigned PW = $clog2(FD);
    localparam int unsigned CW = $clog2(FD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           a_addr_q;
    logic [BW-1:0]           b_addr_q;
    logic                    done_q;

    logic [ROM_LATENCY-1:0]  tag_vld_q;
    logic [ROM_LATENCY-1:0]  tag_last_q;

    logic [FD-1:0][DW-1:0]   fifo_a_q;
    logic [FD-1:0][DW-1:0]   fifo_b_q;
    logic [FD-1:0]           fifo_l_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           cnt_q;

    logic [CW-1:0]           inflight;
    logic                    credit;
    logic                    issue;
    logic                    is_last_grp;
    logic                    push;
    logic                    pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Count groups whose ROM data is still in flight
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    // Credit counts in-flight groups so every returning ROM word has a FIFO slot
    assign credit      = ({1'b0, cnt_q} + {1'b0, inflight}) < (CW + 1)'(FD);
    assign issue       = (state_q == S_RUN) && credit;
    assign is_last_grp = (a_addr_q == AW'(A_DEPTH - LANES));
    assign push        = tag_vld_q[ROM_LATENCY-1];
    assign op_valid    = (cnt_q != '0);
    assign pop         = op_valid & op_ready;

    assign romA_addr = a_addr_q;
    assign romB_addr = b_addr_q;
    assign opA       = fifo_a_q[rd_ptr_q];
    assign opB       = fifo_b_q[rd_ptr_q];
    assign op_last   = fifo_l_q[rd_ptr_q] & op_valid;
    assign done      = done_q;

    // Pass control FSM: address generation and sticky done flag
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= S_IDLE;
            a_addr_q <= '0;
            b_addr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_addr_q <= '0;
                    b_addr_q <= '0;
                    if (start) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (is_last_grp) begin
                            state_q  <= S_DRAIN;
                            a_addr_q <= '0;
                            b_addr_q <= '0;
                        end else begin
                            a_addr_q <= a_addr_q + AW'(LANES);
                            b_addr_q <= (b_addr_q == BW'(B_DEPTH - LANES)) ? '0
                                                                           : b_addr_q + BW'(LANES);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && fifo_l_q[rd_ptr_q]) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // In-flight tag pipe, aligned with the ROM read latency
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_last_q[0] <= issue & is_last_grp;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    // Return FIFO capturing ROM data as each tag emerges
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            fifo_a_q <= '0;
            fifo_b_q <= '0;
            fifo_l_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_a_q[wr_ptr_q] <= romA_q;
                fifo_b_q[wr_ptr_q] <= romB_q;
                fifo_l_q[wr_ptr_q] <= tag_last_q[ROM_LATENCY-1];
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] cyc_q;

    // Saturating cycle counter over RUN and DRAIN, cleared by an honoured start
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            cyc_q <= '0;
        end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            cyc_q <= '0;
        end else if ((state_q == S_RUN || state_q == S_DRAIN) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Testbench for operand_fetch_sequencer: ROM models return data equal to the
// lane address; pass-level scenarios come from a vector table, with hand-written
// sequences for reset values and a mid-pass reset.
module tb_operand_fetch_sequencer;

    localparam int LANES   = 16;
    localparam int A_DEPTH = 4096;
    localparam int B_DEPTH = 64;
    localparam int LAT     = 2;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_l;
    logic                 start;
    logic [11:0]          romA_addr;
    logic [5:0]           romB_addr;
    logic [LANES*8-1:0]   romA_q;
    logic [LANES*8-1:0]   romB_q;
    logic [LANES*8-1:0]   opA;
    logic [LANES*8-1:0]   opB;
    logic                 op_valid;
    logic                 op_ready;
    logic                 op_last;
    logic                 done;
    logic [15:0]          cycle_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    operand_fetch_sequencer #(
        .LANES       (LANES),
        .A_DEPTH     (A_DEPTH),
        .B_DEPTH     (B_DEPTH),
        .ROM_LATENCY (LAT)
    ) dut (
        .clock       (clock),
        .reset_l     (reset_l),
        .start       (start),
        .romA_addr   (romA_addr),
        .romB_addr   (romB_addr),
        .romA_q      (romA_q),
        .romB_q      (romB_q),
        .opA         (opA),
        .opB         (opB),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_last     (op_last),
        .done        (done),
        .cycle_count (cycle_count)
    );

    // Synchronous ROM models with LAT cycles of read latency; data = lane address
    logic [11:0] a_pipe [LAT];
    logic [5:0]  b_pipe [LAT];

    always @(posedge clock) begin
        a_pipe[0] <= romA_addr;
        b_pipe[0] <= romB_addr;
        for (int i = 1; i < LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end

    always_comb begin
        romA_q = '0;
        romB_q = '0;
        for (int i = 0; i < LANES; i++) begin
            romA_q[8*i +: 8] = 8'(a_pipe[LAT-1] + 12'(i));
            romB_q[8*i +: 8] = 8'(b_pipe[LAT-1] + 6'(i));
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_romA_addr"}, romA_addr, 0);
        check({tag, "_romB_addr"}, romB_addr, 0);
        check({tag, "_op_valid"}, op_valid, 0);
        check({tag, "_op_last"}, op_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_opA_zero"}, (opA == '0), 1);
        check({tag, "_opB_zero"}, (opB == '0), 1);
    endtask

    // mode 0: op_ready low in cycles lo..hi, else high; mode 1: high on even cycles
    typedef struct {
        int mode;
        int lo;
        int hi;
        int g1;
        int g2;
        int first;
        int xfers;
        int last;
        int done_c;
        int cc;
    } vec_t;

    vec_t vecs [5];

    task automatic run_pass(input vec_t t, input string tag);
        int first = -1, xfers = 0, last_c = -1, done_c = -1, cc = -1;
        int valid_at_done = -1, done_c1 = -1, last_cnt = 0;
        int data_err = 0, stab_err = 0, addr_err = 0, hold_err = 0;
        bit prev_stall = 1'b0, mism;
        logic [LANES*8-1:0] prevA, prevB;
        logic prevL;

        prevA = '0;
        prevB = '0;
        prevL = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc = 1;
        while (done_c < 0 && cyc < 2000) begin
            if (t.mode == 1) op_ready = (cyc % 2 == 0);
            else             op_ready = !(cyc >= t.lo && cyc <= t.hi);
            start = (cyc == t.g1 || cyc == t.g2);
            @(negedge clock);
            if (cyc == 1) done_c1 = done;
            if (cyc <= 5) begin
                if (romA_addr != 12'(16 * (cyc - 1)) || romB_addr != 6'((16 * (cyc - 1)) % 64))
                    addr_err++;
            end
            if (prev_stall && (!op_valid || opA != prevA || opB != prevB || op_last != prevL))
                stab_err++;
            prev_stall = op_valid && !op_ready;
            prevA = opA;
            prevB = opB;
            prevL = op_last;
            if (op_valid && first < 0) first = cyc;
            if (op_valid && op_ready) begin
                mism = 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    if (opA[8*i +: 8] != 8'((16 * xfers + i) % 256)) mism = 1'b1;
                    if (opB[8*i +: 8] != 8'((16 * xfers) % 64 + i))  mism = 1'b1;
                end
                if (op_last != (xfers == 255)) mism = 1'b1;
                if (mism) data_err++;
                if (op_last) begin
                    last_cnt++;
                    last_c = cyc;
                end
                xfers++;
            end
            if (done && done_c < 0) begin
                done_c = cyc;
                cc = int'(cycle_count);
                valid_at_done = op_valid;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        op_ready = 1'b1;

        check({tag, "_done_clear"}, done_c1, 0);
        check({tag, "_addr_seq"}, addr_err, 0);
        check({tag, "_first_valid"}, first, t.first);
        check({tag, "_xfers"}, xfers, t.xfers);
        check({tag, "_data_order"}, data_err, 0);
        check({tag, "_stable"}, stab_err, 0);
        check({tag, "_last_count"}, last_cnt, 1);
        check({tag, "_last_cycle"}, last_c, t.last);
        check({tag, "_done_cycle"}, done_c, t.done_c);
        check({tag, "_valid_at_done"}, valid_at_done, 0);
        check({tag, "_cycle_count"}, cc, PERF ? t.cc : 0);

        repeat (3) begin
            @(negedge clock);
            if (!done || op_valid || int'(cycle_count) != cc) hold_err++;
            @(posedge clock);
            #1;
        end
        check({tag, "_done_hold"}, hold_err, 0);
    endtask

    initial begin
        vecs[0] = '{mode: 0, lo: 1,   hi: 0,   g1: -1, g2: -1,  first: 4, xfers: 256, last: 259, done_c: 260, cc: 259};
        vecs[1] = '{mode: 0, lo: 100, hi: 119, g1: -1, g2: -1,  first: 4, xfers: 256, last: 279, done_c: 280, cc: 279};
        vecs[2] = '{mode: 1, lo: 0,   hi: 0,   g1: -1, g2: -1,  first: 4, xfers: 256, last: 514, done_c: 515, cc: 514};
        vecs[3] = '{mode: 0, lo: 1,   hi: 0,   g1: 50, g2: 258, first: 4, xfers: 256, last: 259, done_c: 260, cc: 259};
        vecs[4] = '{mode: 0, lo: 1,   hi: 30,  g1: -1, g2: -1,  first: 4, xfers: 256, last: 286, done_c: 287, cc: 286};

        reset_l  = 1'b0;
        start    = 1'b0;
        op_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset_l = 1'b1;

        // First pass from IDLE, the rest restart from DONE
        for (int v = 0; v < 5; v++) begin
            run_pass(vecs[v], $sformatf("v%0d", v));
        end

        // Mid-pass reset at transfer 100 (cycle 104), then a clean pass
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        op_ready = 1'b1;
        cyc = 1;
        while (cyc < 104) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("midrst_busy", op_valid, 1);
        reset_l = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        reset_l = 1'b1;
        run_pass(vecs[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
